// File: rtl/adc_spi_pkg.sv
// Shared constants and state type for the ADC SPI responder.
//   FRAME_BITS      : SCLK rises per conversion frame
//   DATA_BITS       : default conversion result width
//   ADDR_BITS       : channel address width
//   CNT_BITS        : bit-counter width (one frame per wrap)
//   ADDR_FIRST_RISE : counter value at the rise that captures addr MSB
//   DATA_FIRST_FALL : counter value at the fall that drives the data MSB
package adc_spi_pkg;

   localparam int unsigned FRAME_BITS      = 16;
   localparam int unsigned DATA_BITS       = 12;
   localparam int unsigned ADDR_BITS       = 3;
   localparam int unsigned CNT_BITS        = 4;
   localparam int unsigned ADDR_FIRST_RISE = 2;
   localparam int unsigned DATA_FIRST_FALL = 4;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spiState_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with registered rise/fall pulses.
//   iCLK, iRST : system clock, async active-high reset
//   d          : asynchronous input level
//   q          : synchronized level (resets to RST_VAL)
//   rise, fall : one-iCLK pulses on synchronized level changes
module spi_sync_edge #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic iCLK,
   input  logic iRST,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic meta;
   logic qPrev;

   // Synchronizer chain plus one history stage for edge detection.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         meta  <= RST_VAL;
         q     <= RST_VAL;
         qPrev <= RST_VAL;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         meta  <= d;
         q     <= meta;
         qPrev <= q;
         rise  <= q & ~qPrev;
         fall  <= ~q & qPrev;
      end
   end

endmodule

// File: rtl/adc_spi_responder.sv
// Emulates a multi-channel SPI ADC: each 16-SCLK frame captures a 3-bit
// channel address from iDIN and shifts out the sample of the channel
// addressed in the previous frame, MSB first after four leading zeros.
//   iCLK, iRST          : system clock, async active-high reset
//   iCS_n, iSCLK, iDIN  : SPI master signals (asynchronous)
//   iCH_DATA            : per-channel samples, channel n at [n*DATA_BITS +: DATA_BITS]
//   oDOUT               : serial data to master, updated on SCLK falls
//   oCH                 : channel converted in the current frame
//   oACTIVE             : frame in progress
//   oFRAME_DONE, oABORT : one-iCLK event pulses
module adc_spi_responder
   import adc_spi_pkg::*;
#(
   parameter int unsigned NUM_CH    = 8,
   parameter int unsigned DATA_BITS = adc_spi_pkg::DATA_BITS
) (
   input  logic                        iCLK,
   input  logic                        iRST,
   input  logic                        iCS_n,
   input  logic                        iSCLK,
   input  logic                        iDIN,
   input  logic [NUM_CH*DATA_BITS-1:0] iCH_DATA,
   output logic                        oDOUT,
   output logic [ADDR_BITS-1:0]        oCH,
   output logic                        oACTIVE,
   output logic                        oFRAME_DONE,
   output logic                        oABORT
);

   localparam logic [CNT_BITS-1:0] ADDR_RISE_FIRST = CNT_BITS'(ADDR_FIRST_RISE);
   localparam logic [CNT_BITS-1:0] ADDR_RISE_LAST  = CNT_BITS'(ADDR_FIRST_RISE + ADDR_BITS - 1);
   localparam logic [CNT_BITS-1:0] LAST_RISE       = CNT_BITS'(FRAME_BITS - 1);
   localparam logic [CNT_BITS-1:0] DATA_FALL       = CNT_BITS'(DATA_FIRST_FALL);

   logic csSync, csRise, csFall;
   logic sclkSync, sclkRise, sclkFall;
   logic dinMeta, dinSync;
   logic unusedSclkLevel;

   spiState_t                state, stateNext;
   logic [CNT_BITS-1:0]      bitCnt, bitCntNext;
   logic [ADDR_BITS-1:0]     addr, addrNext;
   logic [DATA_BITS-1:0]     word, wordNext;
   logic [DATA_BITS-1:0]     chWord;
   logic [ADDR_BITS-1:0]     chNext;
   logic                     doutNext, activeNext, frameDoneNext, abortNext;

   spi_sync_edge #(.RST_VAL(1'b1)) uCsSync (
      .iCLK (iCLK),
      .iRST (iRST),
      .d    (iCS_n),
      .q    (csSync),
      .rise (csRise),
      .fall (csFall)
   );

   spi_sync_edge #(.RST_VAL(1'b1)) uSclkSync (
      .iCLK (iCLK),
      .iRST (iRST),
      .d    (iSCLK),
      .q    (sclkSync),
      .rise (sclkRise),
      .fall (sclkFall)
   );

   // Only SCLK edges matter; its synchronized level is not needed.
   assign unusedSclkLevel = sclkSync;

   // DIN needs level synchronization only; same latency as the SCLK level.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         dinMeta <= 1'b0;
         dinSync <= 1'b0;
      end else begin
         dinMeta <= iDIN;
         dinSync <= dinMeta;
      end
   end

   // Sample of the channel converted this frame.
   always_comb begin
      chWord = '0;
      for (int n = 0; n < NUM_CH; n++) begin
         if (oCH == ADDR_BITS'(n)) chWord = iCH_DATA[n*DATA_BITS +: DATA_BITS];
      end
   end

   // State and output registers.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state       <= IDLE;
         bitCnt      <= '0;
         addr        <= '0;
         word        <= '0;
         oCH         <= '0;
         oDOUT       <= 1'b0;
         oACTIVE     <= 1'b0;
         oFRAME_DONE <= 1'b0;
         oABORT      <= 1'b0;
      end else begin
         state       <= stateNext;
         bitCnt      <= bitCntNext;
         addr        <= addrNext;
         word        <= wordNext;
         oCH         <= chNext;
         oDOUT       <= doutNext;
         oACTIVE     <= activeNext;
         oFRAME_DONE <= frameDoneNext;
         oABORT      <= abortNext;
      end
   end

   // Next-state and frame sequencing; CS rise has priority over SCLK edges.
   always_comb begin
      stateNext     = state;
      bitCntNext    = bitCnt;
      addrNext      = addr;
      wordNext      = word;
      chNext        = oCH;
      doutNext      = oDOUT;
      frameDoneNext = 1'b0;
      abortNext     = 1'b0;

      unique case (state)
         IDLE: begin
            doutNext = 1'b0;
            if (csFall) begin
               stateNext  = ACTIVE;
               bitCntNext = '0;
               addrNext   = '0;
            end
         end

         ACTIVE: begin
            if (csRise) begin
               // A counter of 0 means no partial frame is outstanding.
               stateNext  = IDLE;
               bitCntNext = '0;
               addrNext   = '0;
               doutNext   = 1'b0;
               abortNext  = (bitCnt != '0);
            end else if (sclkRise && !csSync) begin
               bitCntNext = bitCnt + 1'b1;
               // Address shifts in MSB first over three consecutive rises.
               if (bitCnt >= ADDR_RISE_FIRST && bitCnt <= ADDR_RISE_LAST)
                  addrNext = {addr[ADDR_BITS-2:0], dinSync};
               if (bitCnt == LAST_RISE) begin
                  chNext        = addr;
                  frameDoneNext = 1'b1;
               end
            end else if (sclkFall && !csSync) begin
               if (bitCnt == DATA_FALL) begin
                  // Sample is frozen here for the rest of the frame.
                  wordNext = chWord;
                  doutNext = chWord[DATA_BITS-1];
               end else if (bitCnt > DATA_FALL) begin
                  doutNext = word[DATA_BITS-2];
                  wordNext = {word[DATA_BITS-2:0], 1'b0};
               end else begin
                  doutNext = 1'b0;
               end
            end
         end
      endcase

      activeNext = (stateNext == ACTIVE);
   end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Self-checking bench for adc_spi_responder: an SPI master model drives
// frames, pushes the expected DOUT bit per SCLK rise into a queue and pops
// it when sampling oDOUT just before that rise.
module tb_adc_spi_responder;

   localparam int unsigned NCH  = 8;
   localparam int unsigned DB   = 12;
   localparam int unsigned HALF = 8;

   logic            iCLK = 1'b0;
   logic            iRST;
   logic            iCS_n;
   logic            iSCLK;
   logic            iDIN;
   logic [NCH*DB-1:0] chData;
   logic            oDOUT;
   logic [2:0]      oCH;
   logic            oACTIVE;
   logic            oFRAME_DONE;
   logic            oABORT;

   int nChecks  = 0;
   int nPass    = 0;
   int doneCnt  = 0;
   int abortCnt = 0;
   logic expQ[$];

   adc_spi_responder #(.NUM_CH(NCH), .DATA_BITS(DB)) dut (
      .iCLK        (iCLK),
      .iRST        (iRST),
      .iCS_n       (iCS_n),
      .iSCLK       (iSCLK),
      .iDIN        (iDIN),
      .iCH_DATA    (chData),
      .oDOUT       (oDOUT),
      .oCH         (oCH),
      .oACTIVE     (oACTIVE),
      .oFRAME_DONE (oFRAME_DONE),
      .oABORT      (oABORT)
   );

   always #5 iCLK = ~iCLK;

   // Pulse counters, sampled on the inactive edge.
   always @(negedge iCLK) begin
      if (oFRAME_DONE) doneCnt <= doneCnt + 1;
      if (oABORT)      abortCnt <= abortCnt + 1;
   end

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got === exp) nPass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic waitCyc(input int n);
      repeat (n) @(negedge iCLK);
   endtask

   task automatic setCh(input int ch, input logic [DB-1:0] val);
      chData[ch*DB +: DB] = val;
   endtask

   // One (possibly partial) frame; swapAt > 0 rewrites channel swapCh just
   // before sampling rise swapAt.
   task automatic doFrame(input int nRises, input logic [2:0] addr, input logic [DB-1:0] word,
                          input int swapAt, input int swapCh, input logic [DB-1:0] swapVal,
                          input bit raiseCs);
      logic expBit;
      if (iCS_n) begin
         iCS_n = 1'b0;
         waitCyc(HALF);
         checkVal("active at frame start", 32'(oACTIVE), 32'd1);
      end
      for (int i = 1; i <= nRises; i++) begin
         if (i <= 4) expQ.push_back(1'b0);
         else        expQ.push_back(word[16 - i]);
      end
      for (int i = 1; i <= nRises; i++) begin
         iSCLK = 1'b0;
         iDIN  = (i >= 3 && i <= 5) ? addr[5 - i] : 1'b0;
         waitCyc(HALF);
         if (i == swapAt) setCh(swapCh, swapVal);
         expBit = expQ.pop_front();
         checkVal($sformatf("dout rise %0d", i), 32'(oDOUT), 32'(expBit));
         iSCLK = 1'b1;
         waitCyc(HALF);
      end
      iDIN = 1'b0;
      if (raiseCs) begin
         iCS_n = 1'b1;
         waitCyc(2 * HALF);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks so far %0d", nChecks);
      $fatal(1, "watchdog");
   end

   initial begin
      iRST   = 1'b1;
      iCS_n  = 1'b1;
      iSCLK  = 1'b1;
      iDIN   = 1'b0;
      chData = '0;
      waitCyc(3);
      checkVal("reset dout",  32'(oDOUT),       32'd0);
      checkVal("reset ch",    32'(oCH),         32'd0);
      checkVal("reset active",32'(oACTIVE),     32'd0);
      checkVal("reset done",  32'(oFRAME_DONE), 32'd0);
      checkVal("reset abort", 32'(oABORT),      32'd0);
      iRST = 1'b0;
      waitCyc(4);

      // Basic frame, channel 0.
      setCh(0, 12'hA5C);
      doFrame(16, 3'b000, 12'hA5C, 0, 0, 12'h000, 1'b1);
      checkVal("f1 done count", 32'(doneCnt), 32'd1);
      checkVal("f1 ch",         32'(oCH),     32'd0);
      checkVal("f1 idle",       32'(oACTIVE), 32'd0);
      checkVal("f1 idle dout",  32'(oDOUT),   32'd0);

      // Address 5 in one frame, continuous frame returns channel 5.
      setCh(5, 12'h3F0);
      doFrame(16, 3'b101, 12'hA5C, 0, 0, 12'h000, 1'b0);
      checkVal("cont ch after addr5", 32'(oCH),     32'd5);
      checkVal("cont done count",     32'(doneCnt), 32'd2);
      checkVal("cont still active",   32'(oACTIVE), 32'd1);
      doFrame(16, 3'b000, 12'h3F0, 0, 0, 12'h000, 1'b1);
      checkVal("f3 ch",         32'(oCH),     32'd0);
      checkVal("f3 done count", 32'(doneCnt), 32'd3);

      // Abort after 9 rises with address 6 sent.
      doFrame(9, 3'b110, 12'hA5C, 0, 0, 12'h000, 1'b1);
      checkVal("abort count",      32'(abortCnt), 32'd1);
      checkVal("abort ch kept",    32'(oCH),      32'd0);
      checkVal("abort no done",    32'(doneCnt),  32'd3);
      checkVal("abort dout",       32'(oDOUT),    32'd0);
      checkVal("abort idle",       32'(oACTIVE),  32'd0);

      // Channel 0 changes after the data latch; frame keeps the old sample.
      setCh(0, 12'hFFF);
      doFrame(16, 3'b100, 12'hFFF, 5, 0, 12'h000, 1'b1);
      checkVal("swap ch",         32'(oCH),      32'd4);
      checkVal("swap done count", 32'(doneCnt),  32'd4);

      // Reset around rise 7 of a frame converting channel 4.
      setCh(4, 12'hEA7);
      doFrame(6, 3'b010, 12'hEA7, 0, 0, 12'h000, 1'b0);
      iSCLK = 1'b0;
      waitCyc(HALF);
      checkVal("pre-reset dout", 32'(oDOUT), 32'd1);
      iSCLK = 1'b1;
      waitCyc(2);
      iRST = 1'b1;
      #1;
      checkVal("rst dout",   32'(oDOUT),       32'd0);
      checkVal("rst ch",     32'(oCH),         32'd0);
      checkVal("rst active", 32'(oACTIVE),     32'd0);
      checkVal("rst done",   32'(oFRAME_DONE), 32'd0);
      checkVal("rst abort",  32'(oABORT),      32'd0);
      iCS_n = 1'b1;
      waitCyc(4);
      iRST = 1'b0;
      waitCyc(HALF);
      checkVal("rst no abort pulse", 32'(abortCnt), 32'd1);
      checkVal("rst no done pulse",  32'(doneCnt),  32'd4);
      setCh(0, 12'h6C3);
      doFrame(16, 3'b001, 12'h6C3, 0, 0, 12'h000, 1'b1);
      checkVal("post-rst ch",   32'(oCH),     32'd1);
      checkVal("post-rst done", 32'(doneCnt), 32'd5);

      // SCLK activity with CS high is ignored.
      for (int i = 0; i < 10; i++) begin
         iSCLK = 1'b0;
         waitCyc(HALF);
         iSCLK = 1'b1;
         waitCyc(HALF);
      end
      checkVal("cs high dout",   32'(oDOUT),    32'd0);
      checkVal("cs high active", 32'(oACTIVE),  32'd0);
      checkVal("cs high done",   32'(doneCnt),  32'd5);
      checkVal("cs high abort",  32'(abortCnt), 32'd1);
      setCh(1, 12'h2B4);
      doFrame(16, 3'b000, 12'h2B4, 0, 0, 12'h000, 1'b1);
      checkVal("final ch",   32'(oCH),     32'd0);
      checkVal("final done", 32'(doneCnt), 32'd6);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
